// File: rtl/dino_game_sequencer_pkg.sv
// Dino game sequencer: shared state encodings, geometry defaults and helpers.
// Also consumed by the VGA controller so sprite placement stays in step.
package dino_game_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_HOLD = 2'b10,
        ST_OVER = 2'b11
    } state_t;

    localparam int         DEF_SCORE_DIV   = 16;
    localparam int         DEF_VEL_STEP    = 100;
    localparam logic [4:0] DEF_VEL_MAX     = 5'd20;
    localparam logic [9:0] DEF_SPAWN_X     = 10'd550;
    localparam logic [9:0] DEF_CLOUD_X     = 10'd500;
    localparam logic [9:0] DEF_RESPAWN_LIM = 10'd10;
    localparam int         DEF_HOLD_FRAMES = 30;

    function automatic logic [9:0] sat_sub(input logic [9:0] a, input logic [4:0] b);
        logic [9:0] bx;
        bx = {5'd0, b};
        return (a > bx) ? a - bx : 10'd0;
    endfunction

    function automatic logic [1:0] mod3_next(input logic [1:0] m);
        return (m == 2'd2) ? 2'd0 : m + 2'd1;
    endfunction

endpackage

// File: rtl/dino_game_sequencer_bcd_counter.sv
// Packed-BCD incrementer with synchronous clear, enable and all-nines saturation.
// Increments stop once every digit reads 9.
module bcd_counter #(
    parameter int DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  enable,
    output logic [4*DIGITS-1:0]   value,
    output logic                  saturated
);

    logic [4*DIGITS-1:0] nxt;
    logic                carry;

    assign saturated = (value == {DIGITS{4'h9}});

    always_comb begin
        nxt   = value;
        carry = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (value[4*i +: 4] == 4'd9) begin
                    nxt[4*i +: 4] = 4'd0;
                end else begin
                    nxt[4*i +: 4] = value[4*i +: 4] + 4'd1;
                    carry         = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            value <= '0;
        end else if (clear) begin
            value <= '0;
        end else if (enable && !saturated) begin
            value <= nxt;
        end
    end

endmodule

// File: rtl/dino_game_sequencer.sv
// Dino game controller: IDLE/RUN/HOLD/OVER sequencing, BCD scores and
// once-per-frame scheduling of velocity, cacti and cloud positions.
module dino_game_sequencer
    import dino_game_sequencer_pkg::*;
#(
    parameter int         SCORE_DIV   = DEF_SCORE_DIV,
    parameter int         VEL_STEP    = DEF_VEL_STEP,
    parameter logic [4:0] VEL_MAX     = DEF_VEL_MAX,
    parameter logic [9:0] SPAWN_X     = DEF_SPAWN_X,
    parameter logic [9:0] CLOUD_X     = DEF_CLOUD_X,
    parameter logic [9:0] RESPAWN_LIM = DEF_RESPAWN_LIM,
    parameter int         HOLD_FRAMES = DEF_HOLD_FRAMES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        screen_end,
    input  logic        start,
    input  logic        collision,
    output logic [1:0]  state,
    output logic        game_on,
    output logic        game_over,
    output logic [19:0] curr_bcd,
    output logic [19:0] high_bcd,
    output logic        new_high,
    output logic [4:0]  velocity,
    output logic [9:0]  cacti_x,
    output logic [1:0]  cacti_frame,
    output logic [9:0]  cloud_x
);

    localparam int DIV_W  = $clog2(SCORE_DIV);
    localparam int VEL_W  = $clog2(VEL_STEP);
    localparam int HOLD_W = $clog2(HOLD_FRAMES);

    state_t              fsm, fsm_next;
    logic [2:0]          se_sync, st_sync;
    logic                frame_tick, start_edge;
    logic [DIV_W-1:0]    div_cnt;
    logic [VEL_W-1:0]    vel_cnt;
    logic [HOLD_W-1:0]   hold_cnt;
    logic [1:0]          mod3;
    logic                run_step, restart, hold_enter, hold_done;
    logic                div_wrap, score_sat;

    // Start sync resets high so a button held through reset release gives no edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            se_sync <= 3'b000;
            st_sync <= 3'b111;
        end else begin
            se_sync <= {se_sync[1:0], screen_end};
            st_sync <= {st_sync[1:0], start};
        end
    end

    assign frame_tick = se_sync[1] & ~se_sync[2];
    assign start_edge = st_sync[1] & ~st_sync[2];

    assign run_step   = (fsm == ST_RUN) && !collision && frame_tick;
    assign hold_enter = (fsm == ST_RUN) && collision;
    assign restart    = (fsm == ST_OVER) && start_edge;
    assign hold_done  = (hold_cnt == HOLD_W'(HOLD_FRAMES - 1));
    assign div_wrap   = run_step && (div_cnt == DIV_W'(SCORE_DIV - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fsm <= ST_IDLE;
        end else begin
            fsm <= fsm_next;
        end
    end

    always_comb begin
        fsm_next = fsm;
        unique case (fsm)
            ST_IDLE: if (start_edge) fsm_next = ST_RUN;
            ST_RUN:  if (collision) fsm_next = ST_HOLD;
            ST_HOLD: if (frame_tick && hold_done) fsm_next = ST_OVER;
            ST_OVER: if (start_edge) fsm_next = ST_RUN;
            default: fsm_next = ST_IDLE;
        endcase
    end

    assign state     = fsm;
    assign game_on   = (fsm != ST_IDLE);
    assign game_over = fsm[1];

    bcd_counter #(.DIGITS(5)) u_score (
        .clk       (clk),
        .reset     (reset),
        .clear     (restart),
        .enable    (div_wrap && !score_sat),
        .value     (curr_bcd),
        .saturated (score_sat)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            high_bcd    <= '0;
            new_high    <= 1'b0;
            velocity    <= 5'd1;
            cacti_x     <= SPAWN_X;
            cacti_frame <= 2'd0;
            cloud_x     <= CLOUD_X;
            div_cnt     <= '0;
            vel_cnt     <= '0;
            hold_cnt    <= '0;
            mod3        <= 2'd0;
        end else begin
            // Packed BCD orders the same as binary, so a plain compare works.
            if (hold_enter) begin
                hold_cnt <= '0;
                if (curr_bcd > high_bcd) begin
                    high_bcd <= curr_bcd;
                    new_high <= 1'b1;
                end else begin
                    new_high <= 1'b0;
                end
            end
            if (fsm == ST_HOLD && frame_tick) begin
                hold_cnt <= hold_cnt + 1'b1;
            end
            if (restart) begin
                velocity    <= 5'd1;
                cacti_x     <= SPAWN_X;
                cacti_frame <= 2'd0;
                cloud_x     <= CLOUD_X;
                div_cnt     <= '0;
                vel_cnt     <= '0;
                mod3        <= 2'd0;
            end else if (run_step) begin
                cloud_x <= (cloud_x < RESPAWN_LIM) ? CLOUD_X : cloud_x - 10'd1;
                if (cacti_x < RESPAWN_LIM) begin
                    cacti_x     <= SPAWN_X;
                    cacti_frame <= mod3;
                end else begin
                    cacti_x <= sat_sub(cacti_x, velocity);
                end
                if (div_wrap) begin
                    div_cnt <= '0;
                    mod3    <= mod3_next(mod3);
                    if (vel_cnt == VEL_W'(VEL_STEP - 1)) begin
                        vel_cnt <= '0;
                        if (velocity < VEL_MAX) velocity <= velocity + 5'd1;
                    end else begin
                        vel_cnt <= vel_cnt + 1'b1;
                    end
                end else begin
                    div_cnt <= div_cnt + 1'b1;
                end
            end
        end
    end

endmodule
